// File: rtl/sram_wb_pkg.sv
// -----------------------------------------------------------------------------
// sram_wb_pkg
// Shared types and helpers for the banked Wishbone SRAM slave.
//   state_t   : transaction FSM states
//   bank_bits : width of the bank index; never narrower than one bit, so the
//               bank fields stay legal when only one macro is fitted.
// -----------------------------------------------------------------------------
package sram_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic int bank_bits(input int num_banks);
        return (num_banks <= 1) ? 1 : $clog2(num_banks);
    endfunction

endpackage

// File: rtl/sram_wb_addr_decode.sv
// -----------------------------------------------------------------------------
// sram_wb_addr_decode
// Purely combinational decode of a Wishbone byte address into a bank index and
// a row inside that bank, plus an in-range flag.
// Ports:
//   adr      in  32-bit Wishbone byte address
//   bank     out bank index (bank_bits(NUM_BANKS) wide)
//   row      out word address inside the bank (ADDR_WIDTH)
//   in_range out 1 when the address maps onto a fitted macro
// -----------------------------------------------------------------------------
module sram_wb_addr_decode
    import sram_wb_pkg::*;
#(
    parameter int          NUM_BANKS  = 2,
    parameter int          ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          BANK_W     = bank_bits(NUM_BANKS)
) (
    input  logic [31:0]           adr,
    output logic [BANK_W-1:0]     bank,
    output logic [ADDR_WIDTH-1:0] row,
    output logic                  in_range
);

    // Word index counted from bank 0, word 0. The shift drops the byte
    // offset; an address below the base wraps to a huge word index, but the
    // explicit base comparison below rejects it anyway.
    localparam logic [32:0] WORD_LIMIT = 33'(NUM_BANKS) << ADDR_WIDTH;

    logic [31:0] word;

    assign word     = (adr - BASE_ADDR) >> 2;
    assign row      = word[ADDR_WIDTH-1:0];
    assign bank     = word[ADDR_WIDTH +: BANK_W];
    assign in_range = (adr >= BASE_ADDR) && ({1'b0, word} < WORD_LIMIT);

endmodule

// File: rtl/sram_wb_banked.sv
// -----------------------------------------------------------------------------
// sram_wb_banked
// Wishbone slave fronting NUM_BANKS 1r1w SRAM macros laid out back to back
// from BASE_ADDR. Writes complete in one cycle, reads in three (issue, macro
// access, capture), out-of-range requests answer with err.
// Ports:
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i       Wishbone request qualifiers
//   wbs_sel_i, wbs_dat_i       byte selects and write data
//   wbs_adr_i                  byte address
//   wbs_ack_o/err_o/dat_o      registered Wishbone response
//   sram_csb0_o / sram_csb1_o  per-bank active-low write / read selects
//   sram_addr_o/din_o/wmask_o  address, write data, byte mask shared by banks
//   sram_dout_i                concatenated read data, bank b at b*DATA_WIDTH
// -----------------------------------------------------------------------------
module sram_wb_banked
    import sram_wb_pkg::*;
#(
    parameter int          NUM_BANKS  = 2,
    parameter int          ADDR_WIDTH = 11,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [NUM_WMASKS-1:0]           wbs_sel_i,
    input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
    input  logic [31:0]                     wbs_adr_i,
    output logic                            wbs_ack_o,
    output logic                            wbs_err_o,
    output logic [DATA_WIDTH-1:0]           wbs_dat_o,
    output logic [NUM_BANKS-1:0]            sram_csb0_o,
    output logic [NUM_BANKS-1:0]            sram_csb1_o,
    output logic [ADDR_WIDTH-1:0]           sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_din_o,
    output logic [NUM_WMASKS-1:0]           sram_wmask_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout_i
);

    localparam int BANK_W = bank_bits(NUM_BANKS);

    state_t                  state, state_next;
    logic [BANK_W-1:0]       dec_bank;
    logic [ADDR_WIDTH-1:0]   dec_row;
    logic                    dec_in_range;
    logic [BANK_W-1:0]       bank_q;
    logic [NUM_WMASKS-1:0]   sel_q;
    logic [NUM_BANKS-1:0]    bank_sel_n;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_masked;
    logic                    req;

    sram_wb_addr_decode #(
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .BANK_W     (BANK_W)
    ) u_decode (
        .adr      (wbs_adr_i),
        .bank     (dec_bank),
        .row      (dec_row),
        .in_range (dec_in_range)
    );

    assign req          = wbs_stb_i & wbs_cyc_i;
    assign sram_addr_o  = dec_row;
    assign sram_din_o   = wbs_dat_i;
    assign sram_wmask_o = wbs_sel_i;

    // Active-low one-hot of the decoded bank; only ever applied to a single
    // csb vector, so at most one select is low in any cycle.
    always_comb begin
        bank_sel_n = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (dec_bank == BANK_W'(b)) begin
                bank_sel_n[b] = 1'b0;
            end
        end
    end

    // Read data of the bank latched at issue time, with deselected byte
    // lanes forced to zero.
    always_comb begin
        rd_word   = sram_dout_i[int'(bank_q) * DATA_WIDTH +: DATA_WIDTH];
        rd_masked = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (sel_q[i]) begin
                rd_masked[i*8 +: 8] = rd_word[i*8 +: 8];
            end
        end
    end

    // Next state and macro selects. Selects are only driven in the IDLE
    // accept cycle, and are held off while reset is asserted so that a
    // request sitting on the bus during reset never touches a macro.
    always_comb begin
        state_next  = state;
        sram_csb0_o = '1;
        sram_csb1_o = '1;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!dec_in_range) begin
                        state_next = RESP;
                    end else if (wbs_we_i) begin
                        sram_csb0_o = bank_sel_n;
                        state_next  = RESP;
                    end else begin
                        sram_csb1_o = bank_sel_n;
                        state_next  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_next = wbs_cyc_i ? RD_CAP : IDLE;
            RD_CAP:  state_next = wbs_cyc_i ? RESP : IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!wb_rst_ni) begin
            sram_csb0_o = '1;
            sram_csb1_o = '1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response registers. ack/err are one-cycle pulses that land in the RESP
    // cycle; dat_o only changes when a read is actually acknowledged.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            bank_q    <= '0;
            sel_q     <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!dec_in_range) begin
                            wbs_err_o <= 1'b1;
                        end else if (wbs_we_i) begin
                            wbs_ack_o <= 1'b1;
                        end else begin
                            bank_q <= dec_bank;
                            sel_q  <= wbs_sel_i;
                        end
                    end
                end
                RD_CAP: begin
                    if (wbs_cyc_i) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= rd_masked;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_wb_banked.md
SRAM_WB_BANKED -- requirements
Module: sram_wb_banked

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, meaning the number of 1r1w SRAM macros behind one slave (1, 2, 4 or 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, meaning word-address bits per bank.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning word width; NUM_WMASKS = DATA_WIDTH/8.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the byte address of bank 0, word 0.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock; SRAM macros are clocked from it externally.
REQ-006 SHALL have port wb_rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have Wishbone slave inputs wbs_stb_i, wbs_cyc_i and wbs_we_i (1 each), wbs_sel_i (NUM_WMASKS), wbs_dat_i (DATA_WIDTH) and wbs_adr_i (32, byte address).
REQ-008 SHALL have Wishbone slave outputs wbs_ack_o (1), wbs_err_o (1) and wbs_dat_o (DATA_WIDTH), all registered.
REQ-009 SHALL have outputs sram_csb0_o and sram_csb1_o, NUM_BANKS bits each: per-bank active-low write and read selects.
REQ-010 SHALL have outputs sram_addr_o (ADDR_WIDTH), sram_din_o (DATA_WIDTH) and sram_wmask_o (NUM_WMASKS), shared by all banks.
REQ-011 SHALL have input sram_dout_i (NUM_BANKS*DATA_WIDTH): bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-012 SHALL compute offset = wbs_adr_i - BASE_ADDR and word = offset[31:2]; bank = word[ADDR_WIDTH +: log2(NUM_BANKS)]; row = word[ADDR_WIDTH-1:0].
REQ-013 SHALL treat a request as in range iff wbs_adr_i >= BASE_ADDR and word < NUM_BANKS * 2^ADDR_WIDTH; all other requests are out of range.
REQ-014 SHALL implement an FSM with states IDLE, RD_WAIT, RD_CAP and RESP.
REQ-015 In IDLE, a request (stb & cyc) that is out of range SHALL go to RESP with err pending; no csb is asserted.
REQ-016 In IDLE, an in-range write SHALL drive the bank's csb0 low for exactly that cycle, with addr, din and wmask (= sel) driven combinationally, then go to RESP with ack pending.
REQ-017 In IDLE, an in-range read SHALL drive the bank's csb1 low for that cycle, latch bank and sel, then go to RD_WAIT.
REQ-018 RD_WAIT SHALL go to RD_CAP; RD_CAP SHALL register the selected bank's dout, zero every byte lane whose sel bit is 0, and go to RESP.
REQ-019 In RESP, exactly one of wbs_ack_o and wbs_err_o SHALL be high for one cycle, after which the FSM returns to IDLE.
REQ-020 Latency from request acceptance to ack: write = 1 cycle, read = 3 cycles, error = 1 cycle.
REQ-021 wbs_dat_o SHALL hold its last read value and be valid whenever a read ack is high; write and error responses leave it unchanged.
REQ-022 If wbs_cyc_i drops in RD_WAIT or RD_CAP, the FSM SHALL return to IDLE with no ack or err; a write already issued is not undone.
REQ-023 All csb outputs SHALL be high in every state except the IDLE accept cycle, and at most one csb bit SHALL be low in any cycle.
REQ-024 A request present in the cycle after RESP SHALL be accepted as a new transaction.
REQ-025 wbs_sel_i = 0 on a write SHALL still ack, with wmask = 0 (no bytes written).

Reset
REQ-026 Asserting wb_rst_ni low SHALL immediately force IDLE, ack = 0, err = 0, dat_o = 0 and all csb high, including mid-transaction; the aborted transaction is never acknowledged.

Structure
REQ-027 The FSM state enum and the bank-index width function SHALL live in package sram_wb_pkg.
REQ-028 The address decode (REQ-012/013) SHALL be a sub-module, sram_wb_addr_decode, which is purely combinational.

Verification
REQ-029 Write 0xDEADBEEF to BASE+0x0004 with sel = 0xF: csb0[0] low for one cycle with addr = 1, ack 1 cycle later; a later read returns 0xDEADBEEF with ack 3 cycles after the request.
REQ-030 Write to BASE+0x2000 (word 2048) with NUM_BANKS = 2: csb0[1] low with addr = 0; bank 0 is untouched.
REQ-031 Read BASE+0x4000 with NUM_BANKS = 2: err high for 1 cycle, no ack, no csb low.
REQ-032 Read with sel = 0x5 from a word holding 0x11223344: dat_o = 0x00220044.
REQ-033 Drop cyc in RD_WAIT, and separately pulse wb_rst_ni low in RD_CAP: no ack in either case, FSM returns to IDLE, next request is served normally.
REQ-034 Back-to-back write then read with stb re-asserted the cycle after ack: both acked, and the read returns the written data.
